// File: rtl/proctypes.sv
// Shared processor types: fetch interface, decoded-operation encoding and
// the decoded-entry record that flows from decode to the render units.
package proctypes;

  typedef logic [31:0] InstructionAddr;
  typedef logic [31:0] Instruction;

  typedef enum logic [1:0] {
    fetchStall    = 2'd0,
    fetchDequeue  = 2'd1,
    fetchRedirect = 2'd2,
    fetchFlush    = 2'd3
  } FetchAction;

  typedef enum logic [2:0] {
    dop_CAMERA   = 3'd0,
    dop_LIGHT    = 3'd1,
    dop_SHAPE    = 3'd2,
    dop_XFORM    = 3'd3,
    dop_MATERIAL = 3'd4,
    dop_RENDER   = 3'd5
  } DecodedOp;

  localparam logic [3:0] OPC_NOP      = 4'h0;
  localparam logic [3:0] OPC_CAMERA   = 4'h1;
  localparam logic [3:0] OPC_LIGHT    = 4'h2;
  localparam logic [3:0] OPC_SHAPE    = 4'h3;
  localparam logic [3:0] OPC_XFORM    = 4'h4;
  localparam logic [3:0] OPC_MATERIAL = 4'h5;
  localparam logic [3:0] OPC_RENDER   = 4'h6;
  localparam logic [3:0] OPC_END      = 4'hF;

  typedef struct packed {
    InstructionAddr pc;
    DecodedOp       op;
    logic [3:0]     target;
    logic [31:0]    imm;
  } DecodedEntry;

  // Only meaningful for legal opcodes; other values are never pushed.
  function automatic DecodedOp opc_to_dop(input logic [3:0] opc);
    case (opc)
      OPC_LIGHT:    return dop_LIGHT;
      OPC_SHAPE:    return dop_SHAPE;
      OPC_XFORM:    return dop_XFORM;
      OPC_MATERIAL: return dop_MATERIAL;
      OPC_RENDER:   return dop_RENDER;
      default:      return dop_CAMERA;
    endcase
  endfunction

endpackage

// File: rtl/instruction_decode_fifo.sv
// Synchronous FIFO of decoded entries with occupancy count; storage is
// cleared on reset so the head reads as zero until the first push.
module decoded_fifo
  import proctypes::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  DecodedEntry              din,
  output DecodedEntry              head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  DecodedEntry     mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/instruction_decode.sv
// Decode stage: pulls instructions from fetch, splits them into op/target/imm,
// buffers legal ops for the render units and tracks END and illegal opcodes.
module instruction_decode
  import proctypes::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           instruction_valid,
  input  InstructionAddr pc_in,
  input  Instruction     inst,
  output FetchAction     action,
  output logic           dec_valid,
  input  logic           dec_ready,
  output InstructionAddr dec_pc,
  output DecodedOp       dec_op,
  output logic [3:0]     dec_target,
  output logic [31:0]    dec_imm,
  output logic           halted,
  output logic           illegal_seen,
  output InstructionAddr illegal_pc
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {sIDLE, sRUN, sDRAIN, sHALT} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] count;
  logic [3:0]    opc;
  logic          not_full;
  logic          accept;
  logic          is_legal;
  logic          is_end;
  logic          is_illegal;
  logic          push;
  logic          pop;
  DecodedEntry   entry;
  DecodedEntry   head;

  assign opc        = inst[31:28];
  assign not_full   = (count != CW'(FIFO_DEPTH));
  assign accept     = instruction_valid && (action == fetchDequeue);
  assign is_legal   = (opc >= OPC_CAMERA) && (opc <= OPC_RENDER);
  assign is_end     = (opc == OPC_END);
  assign is_illegal = !is_legal && !is_end && (opc != OPC_NOP);
  assign push       = accept && is_legal;
  assign pop        = dec_valid && dec_ready;

  assign entry.pc     = pc_in;
  assign entry.op     = opc_to_dop(opc);
  assign entry.target = inst[27:24];
  assign entry.imm    = {{8{inst[23]}}, inst[23:0]};

  decoded_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (entry),
    .head  (head),
    .count (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= sIDLE;
    else     state <= state_nxt;
  end

  // Acceptance in sRUN is restated from state/count so action never feeds back
  // into the block that computes it.
  always_comb begin
    state_nxt = state;
    action    = fetchStall;
    case (state)
      sIDLE: if (start) state_nxt = sRUN;
      sRUN: begin
        if (not_full) action = fetchDequeue;
        if (instruction_valid && not_full && is_end) state_nxt = sDRAIN;
      end
      sDRAIN: if (count == '0) state_nxt = sHALT;
      sHALT:  state_nxt = sHALT;
      default: state_nxt = sIDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_seen <= 1'b0;
      illegal_pc   <= '0;
    end else if (accept && is_illegal && !illegal_seen) begin
      illegal_seen <= 1'b1;
      illegal_pc   <= pc_in;
    end
  end

  assign halted     = (state == sHALT);
  assign dec_valid  = (count != '0);
  assign dec_pc     = head.pc;
  assign dec_op     = head.op;
  assign dec_target = head.target;
  assign dec_imm    = head.imm;

endmodule

// File: tb/tb_instruction_decode.sv
// Randomised scoreboard bench for instruction_decode with a fetch stub and a
// spec-level reference model of decode, buffering, END and illegal tracking.
module tb_instruction_decode;
  import proctypes::*;

  localparam int DEPTH = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           instruction_valid;
  InstructionAddr pc_in;
  Instruction     inst;
  FetchAction     action;
  logic           dec_valid;
  logic           dec_ready;
  InstructionAddr dec_pc;
  DecodedOp       dec_op;
  logic [3:0]     dec_target;
  logic [31:0]    dec_imm;
  logic           halted;
  logic           illegal_seen;
  InstructionAddr illegal_pc;

  instruction_decode #(.FIFO_DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .instruction_valid (instruction_valid),
    .pc_in             (pc_in),
    .inst              (inst),
    .action            (action),
    .dec_valid         (dec_valid),
    .dec_ready         (dec_ready),
    .dec_pc            (dec_pc),
    .dec_op            (dec_op),
    .dec_target        (dec_target),
    .dec_imm           (dec_imm),
    .halted            (halted),
    .illegal_seen      (illegal_seen),
    .illegal_pc        (illegal_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned pc;
    int unsigned op;
    int unsigned tgt;
    int unsigned imm;
  } exp_t;

  exp_t        sb[$];
  int unsigned prog[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  int unsigned fpc;
  bit          prev_acc;
  bit          mrun;
  bit          mended;
  bit          m_ill_seen;
  int unsigned m_ill_pc;

  function void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  // Monitor: a pop happens at the next edge whenever head is valid and ready.
  initial begin
    forever begin
      @(negedge clk);
      if (rst !== 1'b1 && dec_valid === 1'b1 && dec_ready === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_pop", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("dec_pc", dec_pc, e.pc);
          chk("dec_op", dec_op, e.op);
          chk("dec_target", dec_target, e.tgt);
          chk("dec_imm", dec_imm, e.imm);
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    instruction_valid = 1'b0;
    inst = '0;
    pc_in = '0;
    dec_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    fpc = 0;
    prev_acc = 0;
    mrun = 0;
    mended = 0;
    m_ill_seen = 0;
    m_ill_pc = 0;
  endtask

  // Reference model for one accepted word.
  task automatic model_accept(input int unsigned w, input int unsigned pc);
    int unsigned opc, imm24;
    exp_t e;
    opc   = w >> 28;
    imm24 = w & 32'h00FF_FFFF;
    if (opc >= 1 && opc <= 6) begin
      e.pc  = pc;
      e.op  = opc - 1;
      e.tgt = (w >> 24) & 15;
      e.imm = (imm24 >= 32'h0080_0000) ? imm24 + 32'hFF00_0000 : imm24;
      sb.push_back(e);
    end else if (opc == 15) begin
      mended = 1;
    end else if (opc != 0 && !m_ill_seen) begin
      m_ill_seen = 1;
      m_ill_pc = pc;
    end
  endtask

  // Called at posedge+#1; returns at posedge+#1.
  task automatic run_phase(input int budget, input int hold, input bit rnd, input bit expect_halt);
    bit acc;
    FetchAction exp_act;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    mrun = 1;
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (prev_acc) fpc++;
      exp_act = (mrun && !mended && sb.size() < DEPTH) ? fetchDequeue : fetchStall;
      chk("action", action, exp_act);
      chk("dec_valid", dec_valid, (sb.size() != 0) ? 1 : 0);
      if (!mended) chk("halted_early", halted, 0);
      if (hold > 0 && cyc == hold) chk("bp_accepted", fpc, DEPTH);
      if (expect_halt && mended && sb.size() == 0 && halted === 1'b1) break;
      instruction_valid = (fpc < prog.size());
      if (fpc < prog.size()) inst = prog[fpc];
      pc_in = fpc;
      dec_ready = (cyc < hold) ? 1'b0 : (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      acc = instruction_valid && (action == fetchDequeue);
      if (acc) model_accept(prog[fpc], fpc);
      prev_acc = acc;
      @(posedge clk); #1;
    end
    if (expect_halt) begin
      chk("halted", halted, 1);
      chk("sb_empty", sb.size(), 0);
    end
    chk("illegal_seen", illegal_seen, m_ill_seen);
    chk("illegal_pc", illegal_pc, m_ill_pc);
  endtask

  initial begin
    // Reset state and idle without start.
    do_reset();
    chk("rst_action", action, fetchStall);
    chk("rst_dec_valid", dec_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_illegal_seen", illegal_seen, 0);
    chk("rst_illegal_pc", illegal_pc, 0);
    chk("rst_dec_pc", dec_pc, 0);
    chk("rst_dec_imm", dec_imm, 0);
    instruction_valid = 1'b1;
    inst = 32'h1200_0010;
    repeat (3) @(posedge clk);
    #1 chk("idle_action", action, fetchStall);
    chk("idle_dec_valid", dec_valid, 0);

    // Basic flow.
    do_reset();
    prog = '{32'h1200_0010, 32'h3500_0020, 32'hF000_0000};
    run_phase(40, 0, 0, 1);

    // Backpressure: four ops offered, only two fit until ready returns.
    do_reset();
    prog = '{32'h1100_0001, 32'h2200_0002, 32'h3300_0003, 32'h4400_0004, 32'hF000_0000};
    run_phase(60, 12, 0, 1);

    // NOP and illegal drops; first illegal pc is kept.
    do_reset();
    prog = '{32'h1000_0001, 32'h2000_0002, 32'h3000_0003, 32'h0000_0000,
             32'h5000_0005, 32'h9000_0000, 32'hA000_0000, 32'h6FFF_FFFF, 32'hF000_0000};
    run_phase(60, 0, 1, 1);
    chk("illegal_pc_5", illegal_pc, 5);

    // END with two entries pending; ready after three cycles; start ignored in halt.
    do_reset();
    prog = '{32'h2300_0100, 32'h5400_0200, 32'hF000_0000};
    run_phase(60, 3, 0, 1);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("halt_sticky", halted, 1);
    chk("halt_action", action, fetchStall);
    chk("halt_dec_valid", dec_valid, 0);

    // Random programs.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      prog.delete();
      for (int i = 0; i < 30; i++)
        prog.push_back(($urandom_range(0, 14) << 28) | ($urandom() & 32'h0FFF_FFFF));
      prog.push_back(32'hF000_0000);
      run_phase(400, 0, 1, 1);
    end

    // Negative immediate, then async reset while one entry is buffered.
    do_reset();
    prog = '{32'h4180_0001};
    run_phase(4, 100, 0, 0);
    chk("neg_dec_valid", dec_valid, 1);
    chk("neg_dec_imm", dec_imm, 32'hFF80_0001);
    chk("neg_dec_target", dec_target, 1);
    #3 rst = 1'b1;
    #1 chk("async_dec_valid", dec_valid, 0);
    chk("async_action", action, fetchStall);
    sb.delete();
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("post_rst_idle_action", action, fetchStall);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
